// File: rtl/stream_demux_buffer.sv
// Purpose: gathers LANES-wide input beats into one MAX-element frame, with early close on flush.
// Latency: out_valid rises the cycle after the completing or flushing accept; the frame is held in registers.
// Backpressure: while a frame is presented, in_ready follows out_ready, so a stalled consumer stalls the producer.
module stream_demux_buffer #(
    parameter int WIDTH = 8,
    parameter int MAX   = 16,
    parameter int LANES = 1   // MAX must be an integer multiple of LANES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data [0:LANES-1],
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data [0:MAX-1],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(MAX+1)-1:0]   count
);

    localparam int BEATS = MAX / LANES;
    localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(MAX + 1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    typedef enum logic {FILL, FULL} state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_q [0:MAX-1];

    // Frame assembly, hand-off and flush padding; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
            for (int e = 0; e < MAX; e++) begin
                data_q[e] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        // Beat lands in slot group idx; untouched slots keep their old contents.
                        for (int e = 0; e < MAX; e++) begin
                            if (e / LANES == int'(idx_q)) begin
                                data_q[e] <= in_data[e % LANES];
                            end
                        end
                        if (int'(idx_q) == BEATS - 1) begin
                            // Completing beat: a simultaneous flush has nothing left to pad.
                            state_q <= FULL;
                            count_q <= CW'(MAX);
                            idx_q   <= '0;
                        end else if (flush) begin
                            // Beat is kept, everything after it is zeroed.
                            for (int e = 0; e < MAX; e++) begin
                                if (e / LANES > int'(idx_q)) begin
                                    data_q[e] <= '0;
                                end
                            end
                            state_q <= FULL;
                            count_q <= CW'((int'(idx_q) + 1) * LANES);
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else if (flush && (idx_q != '0)) begin
                        // Flush of a non-empty partial frame; an empty frame ignores flush.
                        for (int e = 0; e < MAX; e++) begin
                            if (e / LANES >= int'(idx_q)) begin
                                data_q[e] <= '0;
                            end
                        end
                        state_q <= FULL;
                        count_q <= CW'(int'(idx_q) * LANES);
                        idx_q   <= '0;
                    end
                end
                FULL: begin
                    // Flush is meaningless here; without out_ready everything holds.
                    if (out_ready) begin
                        if (in_valid) begin
                            // Hand-off and first beat of the next frame in the same cycle.
                            for (int e = 0; e < MAX; e++) begin
                                if (e / LANES == 0) begin
                                    data_q[e] <= in_data[e % LANES];
                                end
                            end
                            if (BEATS == 1) begin
                                // Single-beat frames: that beat is already a whole frame.
                                count_q <= CW'(MAX);
                                idx_q   <= '0;
                            end else begin
                                state_q <= FILL;
                                count_q <= '0;
                                idx_q   <= IDX_ONE;
                            end
                        end else begin
                            state_q <= FILL;
                            count_q <= '0;
                            idx_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Ready/valid are decoded from the registered state; in_ready is combinational on out_ready in FULL.
    assign in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    assign out_valid = (state_q == FULL);
    assign count     = count_q;
    assign out_data  = data_q;

endmodule

// File: doc/stream_demux_buffer.md
STREAM_DEMUX_BUFFER -- requirements
Module: stream_demux_buffer

Interface
REQ-001 Parameter WIDTH, default 8: bits per element.
REQ-002 Parameter MAX, default 16: elements per output frame.
REQ-003 Parameter LANES, default 1: elements accepted per input beat; MAX SHALL be an integer multiple of LANES, and BEATS = MAX/LANES.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 in_data  input  [WIDTH-1:0] x [0:LANES-1]  input lane elements.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block can accept a beat; a beat is accepted when in_valid && in_ready at posedge.
REQ-009 flush  input  1  close a partial frame early.
REQ-010 out_data  output  [WIDTH-1:0] x [0:MAX-1]  registered frame.
REQ-011 out_valid  output  1  out_data holds a complete or flushed frame.
REQ-012 out_ready  input  1  consumer takes the frame; the frame is taken when out_valid && out_ready at posedge.
REQ-013 count  output  $clog2(MAX+1)  number of valid elements in the presented frame; 0 when out_valid=0.

Function
REQ-014 The block SHALL have two states, FILL and FULL, and a beat index idx in the range 0..BEATS-1.
REQ-015 In FILL, in_ready=1 and out_valid=0.
REQ-016 In FULL, out_valid=1 and in_ready=out_ready, combinationally.
REQ-017 On an accepted beat, lane l SHALL be written to out_data[idx*LANES+l] for l = 0..LANES-1, and idx SHALL increment.
REQ-018 When a beat is accepted at idx=BEATS-1, the block SHALL enter FULL, set count=MAX, and wrap idx to 0.
REQ-019 In FULL with out_ready=1 and no accepted beat, the block SHALL return to FILL with idx=0.
REQ-020 In FULL, if out_ready=1 and a beat is accepted in the same cycle, the frame is handed off and the beat is written as element(s) 0..LANES-1 of the next frame; idx becomes 1.
REQ-021 Under REQ-020, if BEATS=1, the block SHALL stay in FULL with count=MAX, giving one frame per cycle.
REQ-022 In FULL with out_ready=0, out_data, count and idx SHALL hold, and in_ready=0, so no beat is lost.
REQ-023 Flush in FILL with idx>0 and no accepted beat: elements idx*LANES..MAX-1 SHALL be set to 0, count=idx*LANES, and the block enters FULL with idx=0.
REQ-024 Flush simultaneous with an accepted beat: the beat is written first, then the remaining elements are zero-padded, and count=(idx+1)*LANES.
REQ-025 If that flushed beat completes the frame, behaviour SHALL be identical to REQ-018.
REQ-026 Flush in FILL with idx=0 and no accepted beat SHALL be ignored.
REQ-027 Flush in FULL SHALL be ignored.
REQ-028 Output latency: out_valid SHALL rise in the cycle after the completing (or flushing) accept.
REQ-029 Elements SHALL be stored unmodified, with no arithmetic and no sign change.
REQ-030 out_data elements not written in the current frame SHALL retain their prior value until written or zero-padded, except that a flush zero-pads them per REQ-023/024.

Reset
REQ-031 When rst=1 at posedge, the block SHALL enter FILL with idx=0, out_valid=0, count=0, and all out_data elements 0.
REQ-032 Reset SHALL take priority over accept, flush and out_ready in the same cycle.
REQ-033 Reset mid-frame SHALL discard the partial frame.
REQ-034 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-035 WIDTH=8, MAX=4, LANES=1: accept 0x11, 0x22, 0x33, 0x44 on consecutive beats with out_ready=0 -> out_valid=1 the next cycle, out_data={0x11,0x22,0x33,0x44}, count=4, in_ready=0; the frame holds for 5 cycles.
REQ-036 Same configuration, FULL, out_ready=1 and in_valid=1 with 0x55 in the same cycle -> the frame is handed off, the next cycle shows out_valid=0, idx=1, out_data[0]=0x55.
REQ-037 MAX=4, LANES=2: beats {0xA0,0xA1} then {0xB0,0xB1} -> out_data={0xA0,0xA1,0xB0,0xB1}, count=4 after 2 accepts.
REQ-038 MAX=4, LANES=1: accept 0x01 and 0x02, then pulse flush alone -> out_data={0x01,0x02,0x00,0x00}, count=2; flush with idx=0 -> no change, out_valid stays 0.
REQ-039 MAX=4, LANES=1: accept 3 beats, then assert rst together with in_valid and flush -> the next cycle shows out_valid=0, count=0, all out_data=0, in_ready=1; a following 4-beat frame completes normally.
REQ-040 MAX=LANES=2: continuous in_valid=1 and out_ready=1 -> out_valid=1 every cycle from cycle 2, and each frame equals the beat of the previous cycle.
